ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
- Pipeline register between the EX stage and MEM_Stage, using a valid/ready handshake.
- Holds one EX result, plus a one-entry skid buffer so that in_ready is purely registered. Back-pressure from a slow memory does not create a combinational path into EX.
- Drives MEM_Stage read/write/address/writedata directly, and carries writeback control toward WB.
- Supports a synchronous flush for branch/exception squash, and counts MEM-side stall cycles.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- ADDR_W, 16, width of memory address presented to MEM (low bits of ALU result).
- DEST_W, 4, destination register index width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  block can accept this cycle (registered).
- in_wb_en  in  1  instruction writes a register.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_dest  in  DEST_W  destination register.
- in_alu_result  in  DATA_W  ALU result / effective address.
- in_store_data  in  DATA_W  store data.
- out_valid  out  1  main entry valid.
- out_ready  in  1  MEM/WB consumes the main entry this cycle.
- out_wb_en  out  1  main wb_en AND out_valid.
- out_mem_read  out  1  main mem_read AND out_valid.
- out_mem_write  out  1  main mem_write AND out_valid AND out_ready.
- out_dest  out  DEST_W  main destination.
- out_alu_result  out  DATA_W  main ALU result.
- out_address  out  ADDR_W  out_alu_result[ADDR_W-1:0].
- out_store_data  out  DATA_W  main store data.
- stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main entry {valid, payload} and skid entry {valid, payload}. Outputs always come from main.
- in_ready = NOT skid_valid, held in a register (not derived from out_ready). Transfer in = in_valid AND in_ready; transfer out = out_valid AND out_ready.
- Reset: all outputs 0 except in_ready=1. Both valid bits clear, payload registers cleared to 0, stall_count=0.
- States:
  - EMPTY = neither entry valid.
  - ONE = main only.
  - FULL = main and skid.
- EMPTY:
  - in_valid -> main<=in, go to ONE.
  - otherwise stay in EMPTY.
  - out_ready is ignored.
- ONE:
  - in_valid AND out_ready -> main<=in, stay ONE.
  - in_valid AND NOT out_ready -> skid<=in, go to FULL, in_ready falls next cycle.
  - NOT in_valid AND out_ready -> go to EMPTY.
  - neither -> hold.
- FULL:
  - in_ready=0, so inputs are ignored.
  - out_ready -> main<=skid, go to ONE, in_ready rises next cycle.
  - otherwise hold.
- Latency: an input accepted in cycle N is visible on the outputs in cycle N+1 when the block was EMPTY or ONE-with-drain. No bubble is inserted under continuous flow.
- Ordering: strict FIFO order is preserved; the skid entry is never bypassed.
- out_mem_write is gated by out_ready so that a stalled store writes memory exactly once.
- flush:
  - Next state is EMPTY regardless of in_valid/out_ready; any same-cycle transfer-in is discarded.
  - in_ready=1 next cycle.
  - Payload registers may retain stale data, but all control outputs are 0 because they are gated by valid.
- rst has priority over flush; flush has priority over every handshake.
- stall_count increments by 1 per stall cycle, saturates at all-ones (no wrap), and is cleared only by rst, not by flush.
- Width: out_address truncates the ALU result; there is no range check. MEM indexes its 256 words from address bits [7:0].

Decomposition:
- Shared package/header:
  - DATA_W, ADDR_W, DEST_W defaults.
  - Payload field offsets and total width PAYLOAD_W = 3 + DEST_W + 2*DATA_W, so that main and skid are each one packed vector.
  - State encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- No sub-module: the block is a single module. The skid and main entries are two instances of the same packed register, with no separate module for them.

Test Plan:
- Continuous flow: in_valid=1 and out_ready=1 for 10 cycles with alu_result=0..9 -> out_alu_result 0..9 on consecutive cycles, one cycle after acceptance. in_ready stays 1 and stall_count=0.
- Back-pressure:
  - Stimulus: out_ready=0 while sending A=0x10 then B=0x20.
  - in_ready drops after B is accepted and out shows A.
  - 3 stall cycles give stall_count=3.
  - Raising out_ready gives A, then B, then in_ready=1.
- Store once: a store with address 0x0005 and data 0xDEADBEEF is held for 4 cycles with out_ready=0. Expected: out_mem_write=0 for those 4 cycles, then exactly 1 cycle at 1 when out_ready=1, with out_address=0x0005.
- Flush in FULL: flush asserted with both entries valid while in_valid=1 -> next cycle out_valid=0, in_ready=1, out_wb_en=out_mem_read=out_mem_write=0, and the input presented that cycle is lost.
- Reset mid-stall: rst in FULL state with stall_count=7 -> next cycle out_valid=0, in_ready=1, all outputs 0, stall_count=0.
- Saturation: with CNT_W=4, 20 stall cycles -> stall_count=15 and holds at 15.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// ex_mem_pipe_reg_pkg: shared widths, payload layout and state encoding for the EX/MEM register
package ex_mem_pipe_reg_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 16;
  localparam int DEST_W_D = 4;
  localparam int CNT_W_D = 16;
  localparam int WB_BIT = 0;
  localparam int RD_BIT = 1;
  localparam int WR_BIT = 2;
  localparam int DEST_LSB = 3;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  function automatic int alu_lsb(input int dest_w);
    return DEST_LSB + dest_w;
  endfunction
  function automatic int sd_lsb(input int dest_w, input int data_w);
    return DEST_LSB + dest_w + data_w;
  endfunction
  function automatic int payload_w(input int dest_w, input int data_w);
    return 3 + dest_w + 2 * data_w;
  endfunction
endpackage

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register with skid buffer, flush and stall counter
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEST_W = DEST_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_store_data,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int PW = payload_w(DEST_W, DATA_W);
  localparam int ALU_LSB = alu_lsb(DEST_W);
  localparam int SD_LSB = sd_lsb(DEST_W, DATA_W);
  state_t state, state_nx;
  logic [PW-1:0] main, skid, main_nx, skid_nx, in_pay;
  assign in_pay = {in_store_data, in_alu_result, in_dest, in_mem_write, in_mem_read, in_wb_en};
  // next state and entry contents; flush squashes everything and drops any arriving input
  always_comb begin
    state_nx = state;
    main_nx = main;
    skid_nx = skid;
    case (state)
      EMPTY: begin
        main_nx = in_valid ? in_pay : main;
        state_nx = in_valid ? ONE : EMPTY;
      end
      ONE: begin
        main_nx = (in_valid && out_ready) ? in_pay : main;
        skid_nx = (in_valid && !out_ready) ? in_pay : skid;
        state_nx = (in_valid && !out_ready) ? FULL : (!in_valid && out_ready) ? EMPTY : ONE;
      end
      FULL: begin
        main_nx = out_ready ? skid : main;
        state_nx = out_ready ? ONE : FULL;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      main_nx = main;
      skid_nx = skid;
    end
  end
  // state, entries and a registered in_ready that never depends on out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main <= '0;
      skid <= '0;
      in_ready <= 1'b1;
    end else begin
      state <= state_nx;
      main <= main_nx;
      skid <= skid_nx;
      in_ready <= state_nx != FULL;
    end
  end
  // saturating count of cycles where MEM holds off a valid entry
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (out_valid && !out_ready && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
  end
  assign out_valid = state != EMPTY;
  assign out_wb_en = main[WB_BIT] && out_valid;
  assign out_mem_read = main[RD_BIT] && out_valid;
  assign out_mem_write = main[WR_BIT] && out_valid && out_ready;
  assign out_dest = main[DEST_LSB +: DEST_W];
  assign out_alu_result = main[ALU_LSB +: DATA_W];
  assign out_address = out_alu_result[ADDR_W-1:0];
  assign out_store_data = main[SD_LSB +: DATA_W];
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed and random checks of ex_mem_pipe_reg against a queue model
module tb_ex_mem_pipe_reg;
  typedef struct {
    logic wb;
    logic rd;
    logic wr;
    logic [3:0] dest;
    logic [31:0] alu;
    logic [31:0] sd;
  } ent_t;
  logic clk = 0, rst = 1, flush = 0, iv = 0, ordy = 0, wb = 0, rd = 0, wr = 0;
  logic [3:0] dest = 0;
  logic [31:0] alu = 0, sd = 0;
  logic in_ready, out_valid, out_wb_en, out_mem_read, out_mem_write;
  logic [3:0] out_dest;
  logic [31:0] out_alu_result, out_store_data;
  logic [15:0] out_address, stall_count;
  logic in_ready_s, out_valid_s, out_wb_en_s, out_mem_read_s, out_mem_write_s;
  logic [3:0] out_dest_s, stall_s;
  logic [31:0] out_alu_result_s, out_store_data_s;
  logic [15:0] out_address_s;
  int tests = 0, fails = 0;
  ent_t q[$];
  longint scnt = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  ex_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(in_ready),
    .in_wb_en(wb), .in_mem_read(rd), .in_mem_write(wr), .in_dest(dest),
    .in_alu_result(alu), .in_store_data(sd), .out_valid(out_valid), .out_ready(ordy),
    .out_wb_en(out_wb_en), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_dest(out_dest), .out_alu_result(out_alu_result), .out_address(out_address),
    .out_store_data(out_store_data), .stall_count(stall_count)
  );
  ex_mem_pipe_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(in_ready_s),
    .in_wb_en(wb), .in_mem_read(rd), .in_mem_write(wr), .in_dest(dest),
    .in_alu_result(alu), .in_store_data(sd), .out_valid(out_valid_s), .out_ready(ordy),
    .out_wb_en(out_wb_en_s), .out_mem_read(out_mem_read_s), .out_mem_write(out_mem_write_s),
    .out_dest(out_dest_s), .out_alu_result(out_alu_result_s), .out_address(out_address_s),
    .out_store_data(out_store_data_s), .stall_count(stall_s)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_check();
    ent_t h = '{default: 0};
    bit v = q.size() > 0;
    if (v) h = q[0];
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_wb_en", out_wb_en, v && h.wb);
    chk("out_mem_read", out_mem_read, v && h.rd);
    chk("out_mem_write", out_mem_write, v && h.wr && ordy);
    chk("stall_count", stall_count, scnt > 65535 ? 65535 : scnt);
    chk("stall_count_w4", stall_s, scnt > 15 ? 15 : scnt);
    chk("out_valid_w4", out_valid_s, v);
    chk("out_wb_en_w4", out_wb_en_s, v && h.wb);
    chk("out_mem_write_w4", out_mem_write_s, v && h.wr && ordy);
    if (v) begin
      chk("out_dest", out_dest, h.dest);
      chk("out_alu_result", out_alu_result, h.alu);
      chk("out_address", out_address, h.alu[15:0]);
      chk("out_store_data", out_store_data, h.sd);
      chk("out_alu_result_w4", out_alu_result_s, h.alu);
    end
  endtask
  task automatic model_update();
    int n = q.size();
    ent_t e = '{wb: wb, rd: rd, wr: wr, dest: dest, alu: alu, sd: sd};
    if (rst) begin
      q.delete();
      scnt = 0;
      armed = 1;
    end else begin
      if (n > 0 && !ordy) scnt++;
      if (flush) q.delete();
      else begin
        if (n > 0 && ordy) void'(q.pop_front());
        if (iv && n < 2) q.push_back(e);
      end
    end
  endtask
  task automatic cyc();
    #1;
    if (armed) model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic put(input bit v, input logic [31:0] a, input bit r);
    iv = v;
    alu = a;
    ordy = r;
    wb = 1;
    rd = 0;
    wr = 0;
    dest = a[3:0];
    sd = ~a;
  endtask
  initial begin
    @(negedge clk);
    rst = 1;
    cyc();
    cyc();
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_alu_result", out_alu_result, 0);
    chk("reset out_store_data", out_store_data, 0);
    chk("reset stall_count", stall_count, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      put(1, i, 1);
      cyc();
      chk("flow out_alu_result", out_alu_result, i);
      chk("flow out_valid", out_valid, 1);
      chk("flow in_ready", in_ready, 1);
    end
    put(0, 0, 1);
    cyc();
    chk("flow stall_count", stall_count, 0);
    chk("flow drained", out_valid, 0);
    put(1, 32'h10, 0);
    cyc();
    chk("bp A shown", out_alu_result, 32'h10);
    chk("bp in_ready after A", in_ready, 1);
    put(1, 32'h20, 0);
    cyc();
    chk("bp in_ready after B", in_ready, 0);
    chk("bp still A", out_alu_result, 32'h10);
    put(0, 0, 0);
    cyc();
    cyc();
    chk("bp stall_count", stall_count, 3);
    ordy = 1;
    #1 chk("bp A consumed", out_alu_result, 32'h10);
    cyc();
    chk("bp B shown", out_alu_result, 32'h20);
    chk("bp in_ready back", in_ready, 1);
    cyc();
    chk("bp empty", out_valid, 0);
    put(1, 32'h0000_0005, 0);
    wr = 1;
    sd = 32'hDEAD_BEEF;
    cyc();
    put(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("store held no write", out_mem_write, 0);
      cyc();
    end
    ordy = 1;
    #1 chk("store write", out_mem_write, 1);
    chk("store address", out_address, 16'h0005);
    chk("store data", out_store_data, 32'hDEAD_BEEF);
    cyc();
    chk("store written once", out_mem_write, 0);
    put(1, 32'h30, 0);
    rd = 1;
    cyc();
    put(1, 32'h40, 0);
    rd = 1;
    wr = 1;
    cyc();
    chk("flush pre FULL", in_ready, 0);
    put(1, 32'h50, 0);
    flush = 1;
    cyc();
    flush = 0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    chk("flush wb/rd/wr", {out_wb_en, out_mem_read, out_mem_write}, 0);
    put(0, 0, 1);
    cyc();
    chk("flush input lost", out_valid, 0);
    rst = 1;
    cyc();
    rst = 0;
    put(1, 32'h60, 0);
    cyc();
    put(1, 32'h70, 0);
    cyc();
    put(0, 0, 0);
    repeat (6) cyc();
    chk("rst stall pre", stall_count, 7);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst stall_count", stall_count, 0);
    chk("rst outputs", {out_wb_en, out_mem_read, out_mem_write, out_dest, out_alu_result, out_store_data}, 0);
    put(1, 32'h80, 0);
    cyc();
    put(0, 0, 0);
    repeat (20) cyc();
    chk("sat w4", stall_s, 15);
    chk("sat w16", stall_count, 20);
    cyc();
    chk("sat w4 holds", stall_s, 15);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(63) == 0;
      flush = $urandom_range(15) == 0;
      iv = $urandom_range(3) != 0;
      ordy = $urandom_range(2) != 0;
      wb = $urandom_range(1) != 0;
      rd = $urandom_range(1) != 0;
      wr = $urandom_range(1) != 0;
      dest = 4'($urandom);
      alu = $urandom;
      sd = $urandom;
      cyc();
    end
    rst = 0;
    flush = 0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
